devil_active_arbiter: RTL
=========================

DEVIL_ACTIVE_ARBITER -- requirements
Module: devil_active_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the active devil.
REQ-002 SHALL have parameter C_ACE_ADDR_WIDTH, default 44, snoop address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in WAIT cycles.
REQ-004 SHALL have port ace_aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port ace_aresetn  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port i_req  in  NUM_REQ  per-requester request level.
REQ-007 SHALL have port i_req_func  in  4*NUM_REQ  per-requester active function code (ADL/ADT), slice r at [4r+3:4r].
REQ-008 SHALL have port i_req_addr  in  C_ACE_ADDR_WIDTH*NUM_REQ  per-requester snoop address.
REQ-009 SHALL have port i_req_snoop  in  4*NUM_REQ  per-requester AC snoop type.
REQ-010 SHALL have port i_end_active_devil  in  1  completion pulse from active devil.
REQ-011 SHALL have port o_trigger_active  out  1  start level to active devil.
REQ-012 SHALL have ports o_active_func (4), o_active_addr (C_ACE_ADDR_WIDTH), o_active_snoop (4)  out  latched payload of granted requester.
REQ-013 SHALL have ports o_gnt, o_done, o_timeout  out  NUM_REQ each  one-hot grant level, done pulse, timeout pulse.
REQ-014 SHALL have ports o_busy  out  1  and o_fsm_arbiter  out  2  state, for monitoring.

Function
REQ-015 SHALL implement states ARB_IDLE=0, ARB_WAIT=1, ARB_DONE=2; code 3 SHALL return to ARB_IDLE.
REQ-016 In ARB_IDLE with any i_req bit set at edge k, SHALL select the first set bit searching upward from round-robin pointer ptr, wrapping at NUM_REQ-1 to 0.
REQ-017 At edge k SHALL register o_gnt one-hot, func/addr/snoop of selected requester, o_trigger_active=1, o_busy=1, state ARB_WAIT; visible cycle k+1 (one-cycle latency).
REQ-018 Payload outputs SHALL hold constant for the whole ARB_WAIT regardless of requester input changes.
REQ-019 In ARB_WAIT, i_end_active_devil=1 SHALL: clear o_trigger_active and o_gnt, pulse o_done[granted] for exactly one cycle, set ptr=(granted+1) mod NUM_REQ, go ARB_DONE.
REQ-020 ARB_DONE SHALL last exactly one cycle, clear o_busy, then go ARB_IDLE; guarantees trigger low at least two cycles between transactions.
REQ-021 i_end_active_devil in ARB_IDLE or ARB_DONE SHALL be ignored.
REQ-022 Deasserting i_req[granted] during ARB_WAIT SHALL NOT abort; transaction completes normally.
REQ-023 New requests arriving during ARB_WAIT/ARB_DONE SHALL wait; no grant change mid-transaction.
REQ-024 ptr SHALL advance only on completion or timeout, never in ARB_IDLE.

Reset
REQ-025 With ace_aresetn=0 at an edge: state ARB_IDLE, ptr=0, o_gnt/o_done/o_timeout=0, o_trigger_active=0, o_busy=0, payload outputs=0, watchdog counter=0.
REQ-026 Reset during ARB_WAIT SHALL drop o_trigger_active next cycle with no o_done or o_timeout pulse.

Configuration
REQ-027 Macro DEVIL_ARB_TIMEOUT_EN SHALL enable watchdog counter, width $clog2(TIMEOUT_CYCLES+1), cleared on entering ARB_WAIT, +1 per ARB_WAIT cycle without end.
REQ-028 With macro defined: counter reaching TIMEOUT_CYCLES-1 with no end SHALL act as REQ-019 but pulse o_timeout[granted] instead of o_done; end on same cycle SHALL win (o_done only).
REQ-029 Without macro: no counter, ARB_WAIT waits indefinitely, o_timeout tied 0.

Verification
REQ-030 Single: i_req=0001, func=ADT, addr=0x1000, end 5 cycles after trigger -> trigger 1 cycle after req, o_done=0001 one cycle, ptr=1.
REQ-031 Fairness: i_req=1111 held, end 3 cycles after each trigger -> grants 0001,0010,0100,1000,0001 in order.
REQ-032 Spurious end: i_end_active_devil pulsed in ARB_IDLE with i_req=0 -> no state change, no o_done.
REQ-033 Mid-reset: reset asserted 2 cycles into ARB_WAIT -> trigger 0 next cycle, ptr=0, no pulses.
REQ-034 With DEVIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no end -> o_timeout=0001 after 8 WAIT cycles, o_done 0; end on cycle 8 -> o_done only.
REQ-035 Payload hold: change i_req_addr[granted] during ARB_WAIT -> o_active_addr unchanged until ARB_DONE.

Source files
------------

// File: rtl/devil_active_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters access to the shared active devil.
// Optional watchdog enabled by defining DEVIL_ARB_TIMEOUT_EN.
module devil_active_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                          ace_aclk,
    input  logic                          ace_aresetn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [4*NUM_REQ-1:0]          i_req_func,
    input  logic [C_ACE_ADDR_WIDTH*NUM_REQ-1:0] i_req_addr,
    input  logic [4*NUM_REQ-1:0]          i_req_snoop,
    input  logic                          i_end_active_devil,
    output logic                          o_trigger_active,
    output logic [3:0]                    o_active_func,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_active_addr,
    output logic [3:0]                    o_active_snoop,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [NUM_REQ-1:0]            o_timeout,
    output logic                          o_busy,
    output logic [1:0]                    o_fsm_arbiter
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_WAIT = 2'd1;
    localparam logic [1:0] ARB_DONE = 2'd2;

    logic [1:0]                               state, state_nxt;
    logic [IDX_W-1:0]                         ptr, ptr_nxt, gnt_idx, sel;
    logic                                     any_req, tmo_hit;
    logic [NUM_REQ-1:0]                       gnt_oh;
    logic [NUM_REQ-1:0][3:0]                  func_a, snoop_a;
    logic [NUM_REQ-1:0][C_ACE_ADDR_WIDTH-1:0] addr_a;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
        assign func_a[r]  = i_req_func[4*r +: 4];
        assign snoop_a[r] = i_req_snoop[4*r +: 4];
        assign addr_a[r]  = i_req_addr[C_ACE_ADDR_WIDTH*r +: C_ACE_ADDR_WIDTH];
    end

    assign any_req = |i_req;

    // First set request at or above ptr, wrapping past the top requester.
    always_comb begin : p_sel
        int idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && i_req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = 1'b1;
        ptr_nxt         = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

`ifdef DEVIL_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
    logic [WD_W-1:0]    wd_cnt;
    logic [NUM_REQ-1:0] tmo_q;
    assign tmo_hit   = (wd_cnt == WD_W'(TIMEOUT_CYCLES-1));
    assign o_timeout = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = '0;
`endif

    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) state <= ARB_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = ARB_IDLE;
        case (state)
            ARB_IDLE: state_nxt = any_req ? ARB_WAIT : ARB_IDLE;
            ARB_WAIT: state_nxt = (i_end_active_devil || tmo_hit) ? ARB_DONE : ARB_WAIT;
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_trigger_active = (state == ARB_WAIT);
        o_busy           = (state == ARB_WAIT) || (state == ARB_DONE);
        o_gnt            = (state == ARB_WAIT) ? gnt_oh : '0;
        o_fsm_arbiter    = state;
    end

    // Payload and grant index are captured once and frozen for the transaction.
    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            ptr            <= '0;
            gnt_idx        <= '0;
            o_done         <= '0;
            o_active_func  <= '0;
            o_active_addr  <= '0;
            o_active_snoop <= '0;
`ifdef DEVIL_ARB_TIMEOUT_EN
            wd_cnt         <= '0;
            tmo_q          <= '0;
`endif
        end else begin
            o_done <= '0;
`ifdef DEVIL_ARB_TIMEOUT_EN
            tmo_q  <= '0;
`endif
            case (state)
                ARB_IDLE: if (any_req) begin
                    gnt_idx        <= sel;
                    o_active_func  <= func_a[sel];
                    o_active_addr  <= addr_a[sel];
                    o_active_snoop <= snoop_a[sel];
`ifdef DEVIL_ARB_TIMEOUT_EN
                    wd_cnt         <= '0;
`endif
                end
                ARB_WAIT: if (i_end_active_devil) begin
                    o_done <= gnt_oh;
                    ptr    <= ptr_nxt;
                end
`ifdef DEVIL_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_q  <= gnt_oh;
                    ptr    <= ptr_nxt;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
